arrow_scheduler: RTL and testbench

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

---
 rtl/arrow_scheduler.sv | 151 +++++++++++++++
 tb/tb_arrow_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_scheduler.sv
// Two-player arrow scroller: frame-tick-paced shift of pattern codes toward a hit line,
// with per-player key judgement and timed good/bad indicators.
module arrow_scheduler #(
   parameter int unsigned STEP_FRAMES = 4,
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic        iVGA_CLK,
   input  logic        iRST_n,
   input  logic        iVS,
   input  logic        iStart,
   input  logic        iStop,
   input  logic        pat_valid,
   input  logic [2:0]  pat_data,
   output logic        pat_ready,
   input  logic        p1_key_valid,
   input  logic [2:0]  p1_key,
   input  logic        p2_key_valid,
   input  logic [2:0]  p2_key,
   output logic [77:0] player1_indexes,
   output logic [77:0] player2_indexes,
   output logic [1:0]  player1_good_bad,
   output logic [1:0]  player2_good_bad,
   output logic        busy
);

   localparam int unsigned CW  = 3;
   localparam int unsigned AW  = 78;
   localparam int unsigned FCW = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;

   localparam logic [1:0] GB_NONE = 2'b00;
   localparam logic [1:0] GB_GOOD = 2'b01;
   localparam logic [1:0] GB_BAD  = 2'b10;

   logic                      vs_s1_q, vs_s2_q, vs_d_q;
   logic                      tick_c;
   logic [1:0]                state_q, state_d;
   logic [FCW-1:0]            frame_cnt_q, frame_cnt_d;
   logic [1:0][AW-1:0]        arr_q, arr_d;
   logic [1:0][1:0]           gb_q, gb_d;
   logic [1:0][FCW-1:0]       tmr_q, tmr_d;
   logic                      pat_ready_q, pat_ready_d;
   logic                      busy_q, busy_d;
   logic [CW-1:0]             pat_code_c;
   logic [1:0][CW-1:0]        key_c;
   logic [1:0]                kv_c;
   logic [1:0]                hit_c, ev_c;

   assign key_c = {p2_key, p1_key};
   assign kv_c  = {p2_key_valid, p1_key_valid};

   // Falling edge of the synchronised vertical sync marks a new frame.
   assign tick_c = vs_d_q & ~vs_s2_q;

   assign pat_code_c = (pat_valid && pat_data >= 3'd1 && pat_data <= 3'd4) ? pat_data : 3'd0;

   // Per-player judgement against the current hit-line slot.
   always_comb begin
      hit_c = '0;
      ev_c  = '0;
      for (int p = 0; p < 2; p++) begin
         hit_c[p] = kv_c[p] && (arr_q[p][CW-1:0] != '0) && (key_c[p] == arr_q[p][CW-1:0]);
         ev_c[p]  = kv_c[p] || ((state_q == ST_STEP) && (arr_q[p][CW-1:0] != '0));
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      arr_d       = arr_q;
      gb_d        = gb_q;
      tmr_d       = tmr_q;

      case (state_q)
         ST_IDLE: if (iStart) state_d = ST_RUN;
         ST_RUN: begin
            if (tick_c) begin
               if (frame_cnt_q == FCW'(STEP_FRAMES - 1)) begin
                  state_d     = ST_STEP;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + FCW'(1);
               end
            end
         end
         ST_STEP: state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      for (int p = 0; p < 2; p++) begin
         if (hit_c[p] && state_q == ST_RUN) arr_d[p][CW-1:0] = '0;
         if (state_q == ST_STEP) arr_d[p] = {pat_code_c, arr_q[p][AW-1:CW]};
         if (ev_c[p]) begin
            gb_d[p]  = hit_c[p] ? GB_GOOD : GB_BAD;
            tmr_d[p] = FCW'(HOLD_FRAMES);
         end else if (tick_c && tmr_q[p] != '0) begin
            tmr_d[p] = tmr_q[p] - FCW'(1);
            if (tmr_q[p] == FCW'(1)) gb_d[p] = GB_NONE;
         end
      end

      // Stop overrides everything; IDLE keeps all game state cleared.
      if (iStop || state_q == ST_IDLE) begin
         arr_d       = '0;
         gb_d        = '0;
         tmr_d       = '0;
         frame_cnt_d = '0;
      end
      if (iStop) state_d = ST_IDLE;

      pat_ready_d = (state_d == ST_STEP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_s1_q     <= 1'b0;
         vs_s2_q     <= 1'b0;
         vs_d_q      <= 1'b0;
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         arr_q       <= '0;
         gb_q        <= '0;
         tmr_q       <= '0;
         pat_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         vs_s1_q     <= iVS;
         vs_s2_q     <= vs_s1_q;
         vs_d_q      <= vs_s2_q;
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         arr_q       <= arr_d;
         gb_q        <= gb_d;
         tmr_q       <= tmr_d;
         pat_ready_q <= pat_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign player1_indexes  = arr_q[0];
   assign player2_indexes  = arr_q[1];
   assign player1_good_bad = gb_q[0];
   assign player2_good_bad = gb_q[1];
   assign pat_ready        = pat_ready_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Randomised bench for arrow_scheduler: a slot-array game model predicts every cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_arrow_scheduler;

   localparam int SF = 4;
   localparam int HF = 30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ivs = 1'b1;
   logic        start = 1'b0, stop = 1'b0;
   logic        pv = 1'b0;
   logic [2:0]  pd = 3'd0;
   logic        k1v = 1'b0, k2v = 1'b0;
   logic [2:0]  k1 = 3'd0, k2 = 3'd0;
   logic        rdy, bsy;
   logic [77:0] i1, i2;
   logic [1:0]  g1, g2;

   typedef struct packed {
      logic [77:0] i1;
      logic [77:0] i2;
      logic [1:0]  g1;
      logic [1:0]  g2;
      logic        rdy;
      logic        bsy;
   } snap_t;

   snap_t q[$];
   int errors = 0;
   int checks = 0;

   // Game model: 0 idle, 1 running, 2 shift cycle.
   int mode;
   int fc;
   int slot[2][26];
   int ind[2];
   int tmr[2];
   bit h1, h2, h3;

   arrow_scheduler #(.STEP_FRAMES(SF), .HOLD_FRAMES(HF)) dut (
      .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(ivs), .iStart(start), .iStop(stop),
      .pat_valid(pv), .pat_data(pd), .pat_ready(rdy),
      .p1_key_valid(k1v), .p1_key(k1), .p2_key_valid(k2v), .p2_key(k2),
      .player1_indexes(i1), .player2_indexes(i2),
      .player1_good_bad(g1), .player2_good_bad(g2), .busy(bsy)
   );

   always #5 clk = ~clk;

   task automatic clear_game();
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 26; k++) slot[p][k] = 0;
         ind[p] = 0;
         tmr[p] = 0;
      end
      fc = 0;
   endtask

   task automatic mreset();
      clear_game();
      mode = 0;
      h1 = 0; h2 = 0; h3 = 0;
   endtask

   task automatic mstep();
      bit tick;
      int key[2];
      bit kv[2];
      tick = h3 && !h2;
      h3 = h2; h2 = h1; h1 = ivs;
      key[0] = int'(k1); key[1] = int'(k2);
      kv[0] = k1v; kv[1] = k2v;
      if (mode == 0) begin
         if (!stop && start) mode = 1;
      end else if (stop) begin
         clear_game();
         mode = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            bit good, ev;
            good = kv[p] && slot[p][0] != 0 && key[p] == slot[p][0];
            ev   = kv[p] || (mode == 2 && slot[p][0] != 0);
            if (good) slot[p][0] = 0;
            if (ev) begin
               ind[p] = good ? 1 : 2;
               tmr[p] = HF;
            end else if (tick && tmr[p] > 0) begin
               tmr[p] = tmr[p] - 1;
               if (tmr[p] == 0) ind[p] = 0;
            end
         end
         if (mode == 2) begin
            for (int p = 0; p < 2; p++) begin
               for (int k = 0; k < 25; k++) slot[p][k] = slot[p][k+1];
               slot[p][25] = (pv && pd >= 3'd1 && pd <= 3'd4) ? int'(pd) : 0;
            end
            mode = 1;
         end else if (tick) begin
            if (fc == SF - 1) begin
               mode = 2;
               fc = 0;
            end else begin
               fc = fc + 1;
            end
         end
      end
   endtask

   function automatic snap_t model_snap();
      snap_t e;
      e = '0;
      for (int k = 0; k < 26; k++) begin
         e.i1[3*k +: 3] = 3'(slot[0][k]);
         e.i2[3*k +: 3] = 3'(slot[1][k]);
      end
      e.g1  = 2'(ind[0]);
      e.g2  = 2'(ind[1]);
      e.rdy = (mode == 2);
      e.bsy = (mode != 0);
      return e;
   endfunction

   function automatic snap_t dut_snap();
      snap_t g;
      g.i1 = i1; g.i2 = i2; g.g1 = g1; g.g2 = g2; g.rdy = rdy; g.bsy = bsy;
      return g;
   endfunction

   task automatic chk_snap(input string nm, input snap_t exp);
      snap_t got;
      got = dut_snap();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got i1=%h i2=%h gb=%b/%b rdy=%b busy=%b need i1=%h i2=%h gb=%b/%b rdy=%b busy=%b",
                  nm, $time, got.i1, got.i2, got.g1, got.g2, got.rdy, got.bsy,
                  exp.i1, exp.i2, exp.g1, exp.g2, exp.rdy, exp.bsy);
      end
   endtask

   // Predict the post-edge outputs from the inputs seen at this edge.
   always @(posedge clk) begin
      if (!rst_n) mreset();
      else mstep();
      q.push_back(model_snap());
   end

   always @(negedge clk) begin
      if (q.size() > 0) chk_snap("cycle", q.pop_front());
   end

   // Frame generator: 6-cycle frames with a 2-cycle low sync pulse.
   initial begin
      int cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         ivs = (cyc % 6) >= 2;
      end
   end

   initial begin
      bit found;
      repeat (3) @(negedge clk);
      chk_snap("reset_state", '0);
      #2 rst_n = 1'b1;

      // Keys in IDLE are ignored and nothing starts without iStart.
      repeat (10) begin
         @(negedge clk);
         k1v = 1'b1; k1 = 3'd1; k2v = 1'b1; k2 = 3'd2;
      end
      @(negedge clk);
      k1v = 1'b0; k2v = 1'b0;

      // Steady code 3 stream until it reaches the hit line and starts missing.
      start = 1'b1; pv = 1'b1; pd = 3'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (26 * SF * 6 + 80) @(negedge clk);

      // Randomised play; keys often aim at the model's current hit-line code.
      repeat (3000) begin
         @(negedge clk);
         pv    = ($urandom_range(0, 3) != 0);
         pd    = 3'($urandom_range(0, 7));
         k1v   = ($urandom_range(0, 11) == 0);
         k1    = ($urandom_range(0, 1) == 1 && slot[0][0] != 0) ? 3'(slot[0][0]) : 3'($urandom_range(1, 4));
         k2v   = ($urandom_range(0, 11) == 0);
         k2    = ($urandom_range(0, 1) == 1 && slot[1][0] != 0) ? 3'(slot[1][0]) : 3'($urandom_range(1, 4));
         stop  = ($urandom_range(0, 599) == 0);
         start = ($urandom_range(0, 9) == 0);
      end
      k1v = 1'b0; k2v = 1'b0; start = 1'b0; stop = 1'b0; pv = 1'b1; pd = 3'd2;

      // Stop while the shift cycle is in progress.
      if (mode == 0) start = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (mode == 2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL step_wait got no shift cycle within 400 cycles, need one");
      end else begin
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
         chk_snap("stop_in_step", '0);
      end

      // Asynchronous reset in the middle of a run.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (150) begin
         @(negedge clk);
         k1v = ($urandom_range(0, 7) == 0); k1 = 3'($urandom_range(1, 4));
      end
      k1v = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_snap("async_reset", '0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);

      stop = 1'b1;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
